// File: rtl/registers_multiport_pkg.sv
// Shared definitions for the multiport register file: default widths, the
// word/tag types and the write-port bundle.
package registers_multiport_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_TAG_WIDTH  = $clog2(DEF_NUM_REGS);
  localparam int ZERO_REG       = 0;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
  typedef logic [DEF_TAG_WIDTH-1:0]  tag_t;
  typedef logic [DEF_TAG_WIDTH-1:0]  word_address_t;

  typedef struct packed {
    logic  write_enable;
    tag_t  write_tag;
    word_t write_value;
  } write_port_t;

endpackage

// File: rtl/registers_multiport_register_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback or flush,
// with writeback bypass on the read_busy outputs.
module register_scoreboard
  import registers_multiport_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int TAG_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 issue_enable,
  input  logic [TAG_WIDTH-1:0]                 issue_tag,
  input  logic                                 flush,
  input  logic [NUM_WRITE-1:0]                 write_enable,
  input  logic [NUM_WRITE-1:0][TAG_WIDTH-1:0]  write_tag,
  input  logic [NUM_READ-1:0][TAG_WIDTH-1:0]   read_tag,
  output logic [NUM_READ-1:0]                  read_busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Later assignments override earlier ones: writeback < issue < flush.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++)
      if (write_enable[w] && write_tag[w] != TAG_WIDTH'(ZERO_REG))
        busy_d[write_tag[w]] = 1'b0;
    if (issue_enable && issue_tag != TAG_WIDTH'(ZERO_REG))
      busy_d[issue_tag] = 1'b1;
    if (flush)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic wr_hit, iss_hit;
    always_comb begin
      wr_hit = 1'b0;
      for (int w = 0; w < NUM_WRITE; w++)
        if (write_enable[w] && write_tag[w] == read_tag[p]) wr_hit = 1'b1;
      iss_hit = issue_enable && issue_tag == read_tag[p];
      if (read_tag[p] == TAG_WIDTH'(ZERO_REG)) read_busy[p] = 1'b0;
      else read_busy[p] = busy_q[read_tag[p]] && !(wr_hit && !iss_hit);
    end
  end

endmodule

// File: rtl/registers_multiport.sv
// Multiport architectural register file: NUM_WRITE prioritised write ports,
// NUM_READ combinational read ports with same-cycle write bypass.
module registers_multiport
  import registers_multiport_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  localparam int TAG_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_READ-1:0][TAG_WIDTH-1:0]   read_tag,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  read_value,
  output logic [NUM_READ-1:0]                  read_busy,
  input  logic [NUM_WRITE-1:0]                 write_enable,
  input  logic [NUM_WRITE-1:0][TAG_WIDTH-1:0]  write_tag,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] write_value,
  input  logic                                 issue_enable,
  input  logic [TAG_WIDTH-1:0]                 issue_tag,
  input  logic                                 flush
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

  // Ascending scan so the highest-index port lands last and wins.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WRITE; w++)
      if (write_enable[w] && write_tag[w] != TAG_WIDTH'(ZERO_REG))
        regs_d[write_tag[w]] = write_value[w];
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    always_comb begin
      read_value[p] = regs_q[read_tag[p]];
      for (int w = 0; w < NUM_WRITE; w++)
        if (write_enable[w] && write_tag[w] == read_tag[p])
          read_value[p] = write_value[w];
      if (read_tag[p] == TAG_WIDTH'(ZERO_REG)) read_value[p] = '0;
    end
  end

  register_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_sb (
    .clock        (clock),
    .reset        (reset),
    .issue_enable (issue_enable),
    .issue_tag    (issue_tag),
    .flush        (flush),
    .write_enable (write_enable),
    .write_tag    (write_tag),
    .read_tag     (read_tag),
    .read_busy    (read_busy)
  );

endmodule

// File: tb/tb_registers_multiport.sv
// Bench for registers_multiport: directed vector table, reset sequences, then
// random traffic against a behavioural register-file model.
module tb_registers_multiport;

  logic clock, reset;
  logic [1:0][4:0]  rt;
  logic [1:0][31:0] rv;
  logic [1:0]       rb;
  logic [1:0]       we;
  logic [1:0][4:0]  wt;
  logic [1:0][31:0] wv;
  logic             ie;
  logic [4:0]       it;
  logic             fl;

  int total, bad;
  logic [31:0] mem  [32];
  logic        busy [32];

  registers_multiport dut (
    .clock(clock), .reset(reset),
    .read_tag(rt), .read_value(rv), .read_busy(rb),
    .write_enable(we), .write_tag(wt), .write_value(wv),
    .issue_enable(ie), .issue_tag(it), .flush(fl)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(int p);
    logic [31:0] v;
    if (rt[p] == 0) return 32'd0;
    v = mem[rt[p]];
    for (int w = 0; w < 2; w++) if (we[w] && wt[w] == rt[p]) v = wv[w];
    return v;
  endfunction

  function automatic logic exp_busy(int p);
    logic wh, ih;
    if (rt[p] == 0) return 1'b0;
    wh = 1'b0;
    for (int w = 0; w < 2; w++) if (we[w] && wt[w] == rt[p]) wh = 1'b1;
    ih = ie && it == rt[p];
    return busy[rt[p]] && !(wh && !ih);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin mem[r] = 0; busy[r] = 0; end
  endtask

  task automatic model_edge();
    for (int r = 1; r < 32; r++) begin
      logic wh;
      wh = 1'b0;
      for (int w = 0; w < 2; w++) if (we[w] && wt[w] == r) wh = 1'b1;
      if (fl) busy[r] = 1'b0;
      else if (ie && it == r) busy[r] = 1'b1;
      else if (wh) busy[r] = 1'b0;
    end
    for (int w = 0; w < 2; w++) if (we[w] && wt[w] != 0) mem[wt[w]] = wv[w];
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_edge();
    @(negedge clock);
  endtask

  task automatic idle();
    we = 0; wt = 0; wv = 0; ie = 0; it = 0; fl = 0;
  endtask

  typedef struct {
    logic [1:0] we; logic [4:0] wt0, wt1; logic [31:0] wv0, wv1;
    logic ie; logic [4:0] it; logic fl; logic [4:0] rt0, rt1;
    logic [31:0] ev0, ev1; logic [1:0] eb;
  } vec_t;
  vec_t vt [15];

  initial begin
    //        we     wt0   wt1   wv0           wv1    ie  it    fl  rt0   rt1   ev0    ev1    eb
    vt[0]  = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 0, 5'd0, 0, 5'd0, 5'd5, 32'd0, 32'd0, 2'b00};
    vt[1]  = '{2'b11, 5'd3, 5'd3, 32'd7,        32'd9, 0, 5'd0, 0, 5'd3, 5'd0, 32'd9, 32'd0, 2'b00};
    vt[2]  = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 0, 5'd0, 0, 5'd3, 5'd2, 32'd9, 32'd0, 2'b00};
    vt[3]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0, 1, 5'd0, 0, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00};
    vt[4]  = '{2'b01, 5'd4, 5'd0, 32'd11,       32'd0, 0, 5'd0, 0, 5'd3, 5'd4, 32'd9, 32'd11, 2'b00};
    vt[5]  = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 0, 5'd0, 0, 5'd0, 5'd4, 32'd0, 32'd11, 2'b00};
    vt[6]  = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 1, 5'd6, 0, 5'd6, 5'd0, 32'd0, 32'd0, 2'b00};
    vt[7]  = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 0, 5'd0, 0, 5'd6, 5'd0, 32'd0, 32'd0, 2'b01};
    vt[8]  = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 0, 5'd0, 0, 5'd6, 5'd0, 32'd0, 32'd0, 2'b01};
    vt[9]  = '{2'b10, 5'd0, 5'd6, 32'd0,        32'd20, 0, 5'd0, 0, 5'd6, 5'd6, 32'd20, 32'd20, 2'b00};
    vt[10] = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 0, 5'd0, 0, 5'd6, 5'd0, 32'd20, 32'd0, 2'b00};
    vt[11] = '{2'b01, 5'd7, 5'd0, 32'd5,        32'd0, 1, 5'd7, 0, 5'd7, 5'd0, 32'd5, 32'd0, 2'b00};
    vt[12] = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 0, 5'd0, 0, 5'd7, 5'd3, 32'd5, 32'd9, 2'b01};
    vt[13] = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 1, 5'd8, 1, 5'd7, 5'd8, 32'd5, 32'd0, 2'b01};
    vt[14] = '{2'b00, 5'd0, 5'd0, 32'd0,        32'd0, 0, 5'd0, 0, 5'd7, 5'd8, 32'd5, 32'd0, 2'b00};

    total = 0; bad = 0;
    reset = 1'b0; rt = 0; idle(); model_clear();
    #2;
    rt[0] = 5'd3; rt[1] = 5'd31; #1;
    chk("reset_val0", rv[0], 0); chk("reset_val1", rv[1], 0);
    chk("reset_busy", {30'd0, rb}, 0);
    @(negedge clock); reset = 1'b1;

    foreach (vt[i]) begin
      we = vt[i].we; wt[0] = vt[i].wt0; wt[1] = vt[i].wt1;
      wv[0] = vt[i].wv0; wv[1] = vt[i].wv1;
      ie = vt[i].ie; it = vt[i].it; fl = vt[i].fl;
      rt[0] = vt[i].rt0; rt[1] = vt[i].rt1;
      #2;
      chk($sformatf("vec%0d_val0", i), rv[0], vt[i].ev0);
      chk($sformatf("vec%0d_val1", i), rv[1], vt[i].ev1);
      chk($sformatf("vec%0d_busy", i), {30'd0, rb}, {30'd0, vt[i].eb});
      tick();
    end

    // Async reset: stored data and busy vanish before any clock edge.
    idle(); we = 2'b01; wt[0] = 5'd5; wv[0] = 32'hDEAD; ie = 1; it = 5'd10;
    tick(); idle();
    rt[0] = 5'd5; rt[1] = 5'd10; #2;
    chk("pre_reset_r5", rv[0], 32'hDEAD);
    chk("pre_reset_busy10", {31'd0, rb[1]}, 1);
    reset = 1'b0; #1;
    chk("async_reset_r5", rv[0], 0);
    chk("async_reset_busy", {30'd0, rb}, 0);
    model_clear();
    // Write presented while reset is held must be discarded.
    we = 2'b10; wt[1] = 5'd9; wv[1] = 32'h1234;
    tick(); idle(); reset = 1'b1;
    rt[0] = 5'd9; rt[1] = 5'd5; #2;
    chk("reset_drop_r9", rv[0], 0);
    chk("post_reset_busy", {30'd0, rb}, 0);
    tick();

    for (int n = 0; n < 400; n++) begin
      we = 2'($urandom); wv[0] = $urandom; wv[1] = $urandom;
      wt[0] = 5'($urandom_range(0, 7)); wt[1] = 5'($urandom_range(0, 7));
      ie = ($urandom_range(0, 2) == 0); it = 5'($urandom_range(0, 7));
      fl = ($urandom_range(0, 15) == 0);
      rt[0] = 5'($urandom_range(0, 7)); rt[1] = 5'($urandom_range(0, 7));
      #2;
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rnd%0d_val%0d", n, p), rv[p], exp_val(p));
        chk($sformatf("rnd%0d_busy%0d", n, p), {31'd0, rb[p]}, {31'd0, exp_busy(p)});
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/registers_multiport.md
Name: registers_multiport

Overview:
Parametrised successor to the single-write architectural register file. Provides NUM_READ combinational read ports and NUM_WRITE write ports, with same-cycle write-to-read bypass. Includes a per-register busy scoreboard that is set at issue and cleared at writeback. Sits between decode/issue and the writeback stages of the 7-stage pipeline, and removes the need for separate forwarding logic on register-file reads.

Parameters:
DATA_WIDTH, 32, bits per register (word)
NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero
NUM_READ, 2, number of read ports
NUM_WRITE, 2, number of write ports; a higher index has higher priority
TAG_WIDTH, $clog2(NUM_REGS), derived, not overridden; width of tag

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
read_tag  in  NUM_READ x TAG_WIDTH  source register select per read port
read_value  out  NUM_READ x DATA_WIDTH  read data per port, combinational
read_busy  out  NUM_READ  1 = selected register has an outstanding producer
write_enable  in  NUM_WRITE  write strobe per port
write_tag  in  NUM_WRITE x TAG_WIDTH  destination register per write port
write_value  in  NUM_WRITE x DATA_WIDTH  write data per port
issue_enable  in  1  marks issue_tag busy
issue_tag  in  TAG_WIDTH  destination of the instruction being issued
flush  in  1  clears every busy bit (pipeline squash)

Behaviour:
- Reset (reset = 0, asynchronous): all registers become 0 and all busy bits become 0 immediately, independent of clock. Registers stay held while reset is low. Reset asserted mid-write discards that write.
- Writes: on the rising clock edge, each port with write_enable = 1 and write_tag != 0 stores write_value. Writes to register 0 are ignored.
- Write conflict: if two enabled ports target the same tag, the highest-index port wins for both data and busy clear.
- Reads: combinational. Zero-cycle latency from read_tag to read_value.
  - read_tag = 0 returns 0 and read_busy = 0.
  - Bypass: if any enabled write port targets read_tag (nonzero) in the current cycle, read_value returns that port's write_value, using the highest-index match. Otherwise read_value returns the stored value.
- Scoreboard: one busy bit per register; busy[0] is constantly 0.
  - Next busy[r] is resolved in this priority order:
    1. flush sets it to 0.
    2. issue_enable with issue_tag == r sets it to 1.
    3. Any enabled write with write_tag == r sets it to 0.
    4. Otherwise it holds.
  - Issue and writeback to the same tag in the same cycle leave busy = 1, because the new producer wins.
  - flush with issue in the same cycle: all bits clear, and the issue is dropped.
  - flush does not affect register data or writes in the same cycle.
  - issue_tag = 0 is ignored.
- read_busy: the registered busy bit, forced to 0 when an enabled write to that tag occurs this cycle (bypassed writeback), unless issue_enable targets the same tag. read_busy never reflects a same-cycle issue, because busy takes effect the next cycle.
- No stall or backpressure. All inputs are sampled every cycle.

Decomposition:
- Shared definitions package holds:
  - word, tag, word_address typedefs
  - ZERO_REG constant
  - typedefs for write-port bundles: write_enable, write_tag, write_value
- One natural sub-module: register_scoreboard, holding the busy array, its priority logic, and the read_busy bypass.
- Storage, write arbitration, and read bypass stay in the top module.

Test Plan:
1. Reset = 0 mid-run after writing 0xDEAD to r5 -> read r5 = 0 immediately, before the next clock edge. After reset = 1, all read_busy = 0.
2. Port 0 writes r3 = 7 and port 1 writes r3 = 9 in the same cycle -> next cycle read r3 = 9. Same-cycle bypass read of r3 = 9.
3. Write r0 = 0xFFFF_FFFF -> read r0 = 0 and read_busy = 0. Issue_tag = 0 -> busy stays 0.
4. Write r4 = 11 with read_tag[1] = 4 in the same cycle -> read_value[1] = 11 combinationally. Stored value at the next cycle = 11.
5. Issue r6 in cycle N -> read_busy(r6) = 0 in N and 1 in N+1. Writeback r6 = 20 in N+3 -> read_busy = 0 in N+3 (bypass), and busy bit = 0 from N+4.
6. Issue r7 and writeback r7 in the same cycle -> busy = 1 next cycle. Then flush together with issue r8 -> busy r7 = 0 and busy r8 = 0 next cycle.
